fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Forwarding and load-use hazard controller for the 5-stage pipelined CPU.
- Keeps its own shadow copy of the destination/control fields for EX, MEM and WB.
- Drives the 2-bit select of the two EX-stage operand 3-to-1 muxes: 00 = ID/EX register value, 01 = MEM/WB write-back data, 10 = EX/MEM ALU result.
- Also generates the load-use stall and bubble insertion, and keeps a saturating stall counter.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous active-high reset.
- id_valid_i  input  1  ID stage holds a real instruction.
- id_rs_i  input  REG_AW  ID source register A.
- id_rt_i  input  REG_AW  ID source register B.
- id_rd_i  input  REG_AW  ID destination register (already resolved rt/rd).
- id_regwrite_i  input  1  ID instruction writes the register file.
- id_memread_i  input  1  ID instruction is a load.
- id_uses_rt_i  input  1  ID instruction reads rt as an operand.
- flush_i  input  1  taken branch/jump; kill the ID instruction.
- stall_o  output  1  hold PC and IF/ID this cycle.
- fwd_a_o  output  2  select for the EX operand-A mux.
- fwd_b_o  output  2  select for the EX operand-B mux.
- ex_bubble_o  output  1  EX stage currently holds a bubble.
- stall_cnt_o  output  CNT_W  count of stall cycles, saturating.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high (rst_i).
- On a clock edge with rst_i=1, all EX/MEM/WB shadow fields are cleared: valid=0, regwrite=0, memread=0, registers=0. stall_cnt_o=0.
- Output values after reset: stall_o=0, fwd_a_o=fwd_b_o=00, ex_bubble_o=1.
- Shadow pipeline advances on every non-reset edge:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields when id_valid_i & ~stall_o & ~flush_i.
  - Otherwise EX <= bubble (valid=0, regwrite=0, memread=0).
- Any qualifier below that says "valid & regwrite" means both bits are set in that stage's shadow.
- Hazard (combinational): haz = ex_valid & ex_memread & ex_regwrite & (ex_rd != 0) & ((ex_rd == id_rs_i) | (id_uses_rt_i & ex_rd == id_rt_i)).
- stall_o = id_valid_i & ~flush_i & haz.
  - Flush wins over stall: a killed instruction never stalls.
  - Exactly one stall cycle per load-use pair. After the bubble the load sits in MEM, not EX, so haz clears.
- Forwarding selects are combinational from the EX shadow and describe the instruction currently in EX:
  - fwd_a_o = 10 if mem_valid & mem_regwrite & mem_rd != 0 & mem_rd == ex_rs.
  - Else 01 if wb_valid & wb_regwrite & wb_rd != 0 & wb_rd == ex_rs.
  - Else 00.
  - fwd_b_o uses the same rule with ex_rt.
  - EX/MEM has priority over MEM/WB, so the newest value wins.
  - Register 0 is never forwarded.
  - Select 11 is never produced.
- When EX holds a bubble: fwd_a_o = fwd_b_o = 00 and ex_bubble_o = 1.
- A load in MEM is never a 10 source for the dependent instruction, because the load-use stall guarantees it. A load in WB forwards via 01.
- An ID read of the register being written by WB in the same cycle is resolved by the register file, not by this block.
- stall_cnt_o increments by 1 on each edge where stall_o=1 and rst_i=0, and saturates at all-ones.
- Reset asserted mid-stall: all shadow stages bubble on that edge and stall_o drops the following cycle.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with id_valid_i=1 and a load sequence → stall_o=0, fwd_a_o=fwd_b_o=00, ex_bubble_o=1, stall_cnt_o=0 throughout.
- EX/MEM forward: `add $3,$1,$2` then `sub $5,$3,$4` back-to-back → when sub is in EX, fwd_a_o=10, fwd_b_o=00, no stall.
- MEM/WB forward and priority: `add $3`, `add $3`, `or $6,$3,$3` → or in EX sees fwd_a_o=fwd_b_o=10. With the middle instruction replaced by `nop`, the selects are 01.
- Load-use: `lw $4,0($1)` then `add $7,$4,$4` → stall_o=1 for exactly 1 cycle, ex_bubble_o=1 the next cycle, add in EX gets fwd_a_o=fwd_b_o=01, stall_cnt_o=1.
- Register 0 and flush:
  - `add $0,...` then a consumer of $0 → selects stay 00.
  - Load-use pair with flush_i=1 in the stall cycle → stall_o=0 and a bubble enters EX.
- Counter saturation: with CNT_W=2, create 5 load-use stalls → stall_cnt_o reads 1,2,3,3,3.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for a 5-stage pipeline.
// Tracks shadow copies of the EX, MEM and WB destination/control fields,
// drives the two EX operand mux selects, raises the load-use stall (with a
// bubble pushed into EX) and keeps a saturating count of stall cycles.
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              id_uses_rt_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              ex_bubble_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // EX shadow: sources are kept so forwarding can be resolved for the EX instruction
    logic              ex_valid;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;

    // MEM and WB shadows only need to know who they write
    logic              mem_valid;
    logic              mem_regwrite;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_valid;
    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_rd;

    logic              haz;
    logic              advance;
    logic              mem_hit;
    logic              wb_hit;

    // Saturating increment: hold at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

    // Newest producer wins: EX/MEM before MEM/WB; a bubble in EX never forwards
    function automatic logic [1:0] fwd_select(
        input logic              ex_live,
        input logic [REG_AW-1:0] src,
        input logic              mem_ok,
        input logic [REG_AW-1:0] mem_dst,
        input logic              wb_ok,
        input logic [REG_AW-1:0] wb_dst
    );
        logic [1:0] sel;
        sel = SEL_REG;
        if (ex_live) begin
            if (mem_ok && (mem_dst == src)) begin
                sel = SEL_MEM;
            end else if (wb_ok && (wb_dst == src)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    // Load-use detection, stall/advance control and forwarding selects
    always_comb begin
        haz = ex_valid & ex_memread & ex_regwrite & (ex_rd != '0) &
              ((ex_rd == id_rs_i) | (id_uses_rt_i & (ex_rd == id_rt_i)));
        stall_o     = id_valid_i & ~flush_i & haz;
        advance     = id_valid_i & ~stall_o & ~flush_i;
        mem_hit     = mem_valid & mem_regwrite & (mem_rd != '0);
        wb_hit      = wb_valid & wb_regwrite & (wb_rd != '0);
        fwd_a_o     = fwd_select(ex_valid, ex_rs, mem_hit, mem_rd, wb_hit, wb_rd);
        fwd_b_o     = fwd_select(ex_valid, ex_rt, mem_hit, mem_rd, wb_hit, wb_rd);
        ex_bubble_o = ~ex_valid;
    end

    // Shadow pipeline: WB <= MEM <= EX <= ID (or a bubble when ID cannot issue)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_rd       <= '0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= '0;
        end else begin
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_rd        <= mem_rd;
            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_rd       <= ex_rd;
            if (advance) begin
                ex_valid    <= 1'b1;
                ex_regwrite <= id_regwrite_i;
                ex_memread  <= id_memread_i;
                ex_rs       <= id_rs_i;
                ex_rt       <= id_rt_i;
                ex_rd       <= id_rd_i;
            end else begin
                ex_valid    <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
            end
        end
    end

    // Stall cycle counter, saturating at all-ones
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o) begin
            stall_cnt_o <= sat_inc(stall_cnt_o);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed, table-driven bench for fwd_hazard_unit. Each table row is one
// clock cycle: ID-side inputs plus the outputs expected in that cycle.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        id_uses_rt;
    logic        flush;
    logic        stall;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        ex_bubble;
    logic [15:0] stall_cnt;
    logic        stall2;
    logic [1:0]  fwd_a2;
    logic [1:0]  fwd_b2;
    logic        ex_bubble2;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int errors = 0;

    fwd_hazard_unit dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
        .id_uses_rt_i(id_uses_rt), .flush_i(flush),
        .stall_o(stall), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
        .ex_bubble_o(ex_bubble), .stall_cnt_o(stall_cnt)
    );

    fwd_hazard_unit #(.REG_AW(5), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
        .id_uses_rt_i(id_uses_rt), .flush_i(flush),
        .stall_o(stall2), .fwd_a_o(fwd_a2), .fwd_b_o(fwd_b2),
        .ex_bubble_o(ex_bubble2), .stall_cnt_o(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        urt;
        logic        fl;
        logic        chk;
        logic        st;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        bub;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 53;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic rst_v, input logic v, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic rw, input logic mr, input logic urt,
        input logic fl, input logic chk, input logic st, input logic [1:0] fa,
        input logic [1:0] fb, input logic bub, input logic [15:0] cnt);
        vec_t r;
        r.rst = rst_v; r.v = v; r.rs = rs; r.rt = rt; r.rd = rd;
        r.rw = rw; r.mr = mr; r.urt = urt; r.fl = fl; r.chk = chk;
        r.st = st; r.fa = fa; r.fb = fb; r.bub = bub; r.cnt = cnt;
        return r;
    endfunction

    task automatic drive(input logic r, input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic urt, input logic fl);
        rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_regwrite = rw; id_memread = mr; id_uses_rt = urt; flush = fl;
    endtask

    task automatic check_row(input int idx, input logic st, input logic [1:0] fa,
                             input logic [1:0] fb, input logic bub, input logic [15:0] cnt);
        checks++;
        if ({stall, fwd_a, fwd_b, ex_bubble, stall_cnt} !== {st, fa, fb, bub, cnt}) begin
            errors++;
            $display("FAIL row%0d: got stall=%b fa=%b fb=%b bub=%b cnt=%0d, expected stall=%b fa=%b fb=%b bub=%b cnt=%0d",
                     idx, stall, fwd_a, fwd_b, ex_bubble, stall_cnt, st, fa, fb, bub, cnt);
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        //             rst v  rs rt rd rw mr urt fl chk  st fa     fb     bub cnt
        // reset held two cycles while a load-use pair sits in ID
        tbl[0]  = mk(1, 1, 1, 0, 4, 1, 1, 0, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        tbl[1]  = mk(1, 1, 4, 4, 7, 1, 0, 1, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        // add $3,$1,$2 ; sub $5,$3,$4 -> EX/MEM forward on A
        tbl[3]  = mk(0, 1, 1, 2, 3, 1, 0, 1, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        tbl[4]  = mk(0, 1, 3, 4, 5, 1, 0, 1, 0, 1,  0, 2'b00, 2'b00, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b10, 2'b00, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        // add $3 ; add $3 ; or $6,$3,$3 -> newest (EX/MEM) wins on both
        tbl[8]  = mk(0, 1, 1, 2, 3, 1, 0, 1, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        tbl[9]  = mk(0, 1, 1, 2, 3, 1, 0, 1, 0, 1,  0, 2'b00, 2'b00, 0, 0);
        tbl[10] = mk(0, 1, 3, 3, 6, 1, 0, 1, 0, 1,  0, 2'b00, 2'b00, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b10, 2'b10, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        // add $3 ; nop ; or $6,$3,$3 -> MEM/WB forward on both
        tbl[14] = mk(0, 1, 1, 2, 3, 1, 0, 1, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 0, 0);
        tbl[16] = mk(0, 1, 3, 3, 6, 1, 0, 1, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b01, 2'b01, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        // lw $4,0($1) ; add $7,$4,$4 -> one stall, bubble, then 01/01
        tbl[20] = mk(0, 1, 1, 4, 4, 1, 1, 0, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        tbl[21] = mk(0, 1, 4, 4, 7, 1, 0, 1, 0, 1,  1, 2'b00, 2'b00, 0, 0);
        tbl[22] = mk(0, 1, 4, 4, 7, 1, 0, 1, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b01, 2'b01, 0, 1);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        // add $0,$1,$2 ; or $6,$0,$0 -> register 0 never forwarded
        tbl[26] = mk(0, 1, 1, 2, 0, 1, 0, 1, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        tbl[27] = mk(0, 1, 0, 0, 6, 1, 0, 1, 0, 1,  0, 2'b00, 2'b00, 0, 1);
        tbl[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 0, 1);
        tbl[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        tbl[30] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        // lw $0 ; add $7,$0,$0 -> no stall on register 0
        tbl[31] = mk(0, 1, 1, 0, 0, 1, 1, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        tbl[32] = mk(0, 1, 0, 0, 7, 1, 0, 1, 0, 1,  0, 2'b00, 2'b00, 0, 1);
        tbl[33] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 0, 1);
        tbl[34] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        tbl[35] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        // load-use pair with flush in the would-be stall cycle
        tbl[36] = mk(0, 1, 1, 4, 4, 1, 1, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        tbl[37] = mk(0, 1, 4, 4, 7, 1, 0, 1, 1, 1,  0, 2'b00, 2'b00, 0, 1);
        tbl[38] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        tbl[39] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        tbl[40] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        // lw $4 then an instruction whose rt matches but is not read: no stall
        tbl[41] = mk(0, 1, 1, 4, 4, 1, 1, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        tbl[42] = mk(0, 1, 2, 4, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 0, 1);
        tbl[43] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 1);
        tbl[44] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        tbl[45] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        tbl[46] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        // reset asserted during a stall cycle
        tbl[47] = mk(0, 1, 1, 4, 4, 1, 1, 0, 0, 1,  0, 2'b00, 2'b00, 1, 1);
        tbl[48] = mk(1, 1, 4, 4, 7, 1, 0, 1, 0, 1,  1, 2'b00, 2'b00, 0, 1);
        tbl[49] = mk(0, 1, 4, 4, 7, 1, 0, 1, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        tbl[50] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 0, 0);
        tbl[51] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 0);
        tbl[52] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 2'b00, 2'b00, 1, 0);

        // bring both instances out of power-up into a known reset state
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd,
                  tbl[i].rw, tbl[i].mr, tbl[i].urt, tbl[i].fl);
            #1;
            if (tbl[i].chk) begin
                check_row(i, tbl[i].st, tbl[i].fa, tbl[i].fb, tbl[i].bub, tbl[i].cnt);
            end
        end

        // five back-to-back load-use pairs: 2-bit counter saturates at 3
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive(0, 1, 1, 4, 4, 1, 1, 0, 0);
            @(negedge clk);
            drive(0, 1, 4, 4, 7, 1, 0, 1, 0);
            #1;
            check_val($sformatf("sat_stall%0d", k), 16'(stall2), 16'd1);
            @(negedge clk);
            #1;
            check_val($sformatf("sat_cnt2_%0d", k), 16'(stall_cnt2), (k < 3) ? 16'(k) : 16'd3);
            check_val($sformatf("sat_cnt16_%0d", k), stall_cnt, 16'(k));
        end

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
